// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage register with one-entry skid buffer
// Exception bubbling, flush, and saturating stall/kill counters.
module pipe_stage_buf #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int CTRL_W = 24,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_except,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_except,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
);

  // State encoding doubles as the resident-entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic              except;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q;
  entry_t            main_q;
  entry_t            skid_q;
  entry_t            in_ent;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  kill_q, kill_d;
  logic [CNT_W:0]    kill_sum;
  logic [1:0]        kill_inc;
  logic              accept;
  logic              fire;

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  assign out_except = main_q.except;
  assign out_pc     = main_q.pc;
  assign out_inst   = main_q.inst;
  assign out_ctrl   = main_q.ctrl;
  assign out_data   = main_q.data;
  assign stall_cnt  = stall_q;
  assign kill_cnt   = kill_q;

  // An excepting entry travels as a bubble: identity kept, side effects zeroed.
  always_comb begin
    in_ent.except = in_except;
    in_ent.pc     = in_pc;
    in_ent.inst   = in_inst;
    in_ent.ctrl   = in_except ? '0 : in_ctrl;
    in_ent.data   = in_except ? '0 : in_data;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
    kill_inc = occupancy - {1'b0, fire};
    kill_sum = {1'b0, kill_q} + {{(CNT_W-1){1'b0}}, kill_inc};
    kill_d   = kill_q;
    if (flush)
      kill_d = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      kill_q  <= '0;
    end else begin
      stall_q <= stall_d;
      kill_q  <= kill_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_q  <= in_ent;
            state_q <= S_MAIN;
          end
        end
        S_MAIN: begin
          if (accept && fire) begin
            main_q <= in_ent;
          end else if (accept) begin
            skid_q  <= in_ent;
            state_q <= S_FULL;
          end else if (fire) begin
            main_q  <= '0;
            state_q <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (fire) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            state_q <= S_MAIN;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed bench for pipe_stage_buf
// Counters built 4 bits wide so saturation is reachable quickly.
module tb_pipe_stage_buf;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CTRL_W = 24;
  localparam int DATA_W = 256;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_except;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_except;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  kill_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(
    .PC_W(PC_W), .INST_W(INST_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_except(in_except),
    .in_pc(in_pc), .in_inst(in_inst), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_except(out_except),
    .out_pc(out_pc), .out_inst(out_inst), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] data);
    in_valid  = 1'b1;
    in_except = 1'b0;
    in_pc     = pc;
    in_inst   = 32'h13;
    in_ctrl   = 24'h5;
    in_data   = data;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_except = 1'b0;
    in_pc = '0; in_inst = '0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_kill", kill_cnt, 0);
    check("rst_except", out_except, 0);
    in_valid = 1'b1;
    tick();
    check("rst_hold_valid", out_valid, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // streaming
    out_ready = 1'b1;
    offer(64'h1000, 256'h7);
    tick();
    check("str0_valid", out_valid, 1);
    check("str0_pc", out_pc, 64'h1000);
    check("str0_occ", occupancy, 1);
    offer(64'h1004, 256'h7);
    tick();
    check("str1_pc", out_pc, 64'h1004);
    check("str1_occ", occupancy, 1);
    offer(64'h1008, 256'h7);
    tick();
    check("str2_pc", out_pc, 64'h1008);
    check("str2_occ", occupancy, 1);
    check("str_stall", stall_cnt, 0);
    in_valid = 1'b0;
    tick();
    check("str_drain_valid", out_valid, 0);
    check("str_drain_occ", occupancy, 0);

    // backpressure
    out_ready = 1'b0;
    offer(64'h3000, 256'hA);
    tick();
    check("bp_a_occ", occupancy, 1);
    check("bp_a_pc", out_pc, 64'h3000);
    offer(64'h3004, 256'hB);
    tick();
    check("bp_b_occ", occupancy, 2);
    check("bp_b_ready", in_ready, 0);
    check("bp_b_pc", out_pc, 64'h3000);
    check("bp_stall1", stall_cnt, 1);
    in_valid = 1'b0;
    tick();
    check("bp_stall2", stall_cnt, 2);
    check("bp_hold_pc", out_pc, 64'h3000);
    tick();
    check("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    tick();
    check("bp_fireA_pc", out_pc, 64'h3004);
    check("bp_fireA_data", out_data, 256'hB);
    check("bp_fireA_ready", in_ready, 1);
    check("bp_fireA_occ", occupancy, 1);
    check("bp_stall_hold", stall_cnt, 3);
    tick();
    check("bp_fireB_valid", out_valid, 0);

    // exception bubble
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_except = 1'b1;
    in_pc     = 64'h2000;
    in_inst   = 32'h00000073;
    in_ctrl   = 24'hFFFFFF;
    in_data   = '1;
    tick();
    check("exc_except", out_except, 1);
    check("exc_pc", out_pc, 64'h2000);
    check("exc_inst", out_inst, 32'h00000073);
    check("exc_ctrl", out_ctrl, 0);
    check("exc_data", out_data, 0);
    in_valid  = 1'b0;
    in_except = 1'b0;
    out_ready = 1'b1;
    tick();
    check("exc_drain", out_valid, 0);
    check("exc_stall", stall_cnt, 3);

    // flush in FULL with fire and a new offer
    out_ready = 1'b0;
    offer(64'h4000, 256'hAA);
    tick();
    offer(64'h4004, 256'hCC);
    tick();
    check("fl_full_occ", occupancy, 2);
    check("fl_full_stall", stall_cnt, 4);
    flush     = 1'b1;
    out_ready = 1'b1;
    offer(64'h5000, 256'hBB);
    tick();
    check("fl_occ", occupancy, 0);
    check("fl_valid", out_valid, 0);
    check("fl_data", out_data, 0);
    check("fl_kill", kill_cnt, 1);
    check("fl_stall", stall_cnt, 4);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl_no_leak_valid", out_valid, 0);
    check("fl_no_leak_pc", out_pc, 0);
    check("fl_ready", in_ready, 1);

    // flush in MAIN without fire
    out_ready = 1'b0;
    offer(64'h4100, 256'h1);
    tick();
    flush    = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    check("flm_kill", kill_cnt, 2);
    check("flm_occ", occupancy, 0);
    check("flm_stall", stall_cnt, 5);

    // stall saturation
    offer(64'h7000, 256'h3);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", stall_cnt, 15);
    tick();
    check("sat_stall_hold", stall_cnt, 15);
    check("sat_pc_stable", out_pc, 64'h7000);

    // asynchronous reset while FULL
    offer(64'h7004, 256'h4);
    tick();
    in_valid = 1'b0;
    check("ar_full_occ", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_occ", occupancy, 0);
    check("ar_stall", stall_cnt, 0);
    check("ar_kill", kill_cnt, 0);
    check("ar_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(64'h6000, 256'h9);
    tick();
    check("post_rst_pc", out_pc, 64'h6000);
    check("post_rst_data", out_data, 256'h9);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
